// File: rtl/clk_div_monitor.sv
// Measures high phase, low phase and period of an asynchronous divided clock in clk cycles
// and flags phases outside EXP_HIGH/EXP_LOW +/- TOL. Optional no-edge watchdog: DIVMON_TIMEOUT_EN.
`timescale 1ns/1ps
module clk_div_monitor #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EXP_HIGH    = 4,
  parameter int EXP_LOW     = 3,
  parameter int TOL         = 0,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             clk_in,
  output logic             meas_valid,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W:0]   period_cnt,
  output logic             err,
  output logic             err_sticky,
  output logic             stuck
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] EXP_H_C = CNT_W'(EXP_HIGH);
  localparam logic [CNT_W-1:0] EXP_L_C = CNT_W'(EXP_LOW);
  localparam logic [CNT_W-1:0] TOL_C   = CNT_W'(TOL);

  function automatic logic [CNT_W-1:0] absdiff(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic                   s, rise, fall;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d, hold_hi_q;
  logic [CNT_W-1:0]       high_q, low_q;
  logic [CNT_W:0]         period_q;
  logic                   meas_valid_q, err_q, err_sticky_q, stuck_q;
  logic                   timeout, close, meas_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_in};
      s_d_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d_q;
  assign fall = ~s & s_d_q;

`ifdef DIVMON_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] noedge_q;

  assign timeout = en && !(rise || fall) && (noedge_q == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      noedge_q <= '0;
    end else if (rise || fall || !en || timeout) begin
      noedge_q <= '0;
    end else begin
      noedge_q <= noedge_q + TO_W'(1);
    end
  end
`else
  // Watchdog compiled out; the expression is constant 0 for any legal TIMEOUT_CYC.
  assign timeout = (TIMEOUT_CYC < 0);
`endif

  // Saturating increment: a stuck phase pins at CNT_MAX rather than wrapping.
  assign cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
  assign close    = en && !timeout && (state_q == LOW) && rise;
  assign meas_err = (absdiff(hold_hi_q, EXP_H_C) > TOL_C) ||
                    (absdiff(cnt_q, EXP_L_C) > TOL_C) ||
                    (hold_hi_q == CNT_MAX) || (cnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hold_hi_q    <= '0;
      high_q       <= '0;
      low_q        <= '0;
      period_q     <= '0;
      meas_valid_q <= 1'b0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
      stuck_q      <= 1'b0;
    end else begin
      meas_valid_q <= 1'b0;
      err_q        <= 1'b0;
      stuck_q      <= timeout;
      if (!en || timeout) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (rise) begin
              state_q <= HIGH;
              cnt_q   <= CNT_ONE;
            end
          end
          HIGH: begin
            if (fall) begin
              hold_hi_q <= cnt_q;
              cnt_q     <= CNT_ONE;
              state_q   <= LOW;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          LOW: begin
            if (rise) begin
              high_q       <= hold_hi_q;
              low_q        <= cnt_q;
              period_q     <= {1'b0, hold_hi_q} + {1'b0, cnt_q};
              meas_valid_q <= 1'b1;
              err_q        <= meas_err;
              cnt_q        <= CNT_ONE;
              state_q      <= HIGH;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
      // A new error outranks a simultaneous clear.
      if ((close && meas_err) || timeout) begin
        err_sticky_q <= 1'b1;
      end else if (clr) begin
        err_sticky_q <= 1'b0;
      end
    end
  end

  assign meas_valid = meas_valid_q;
  assign high_cnt   = high_q;
  assign low_cnt    = low_q;
  assign period_cnt = period_q;
  assign err        = err_q;
  assign err_sticky = err_sticky_q;
  assign stuck      = stuck_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: three instances (nominal, TOL=1, half-integer setup) share one
// stimulus; a per-instance queue of expected measurements is checked whenever meas_valid fires.
`timescale 1ns/1ps
module tb_clk_div_monitor;
  localparam int SYNC   = 2;
  localparam int TO_CYC = 64;

  typedef struct {
    int   h;
    int   l;
    int   p;
    logic e;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, en, clr, clk_in;
  logic       mv [3];
  logic [7:0] hc [3];
  logic [7:0] lc [3];
  logic [8:0] pc [3];
  logic       er [3];
  logic       es [3];
  logic       st [3];

  exp_t q0[$], q1[$], q2[$];
  int   n_chk = 0, n_pass = 0, stuck_seen = 0;
  int   last_h = 0, last_l = 0, cnt;

  always #5 clk = ~clk;

  clk_div_monitor #(.CNT_W(8), .SYNC_STAGES(SYNC), .EXP_HIGH(4), .EXP_LOW(3), .TOL(0),
                    .TIMEOUT_CYC(TO_CYC)) u_def (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .clk_in(clk_in), .meas_valid(mv[0]),
    .high_cnt(hc[0]), .low_cnt(lc[0]), .period_cnt(pc[0]), .err(er[0]),
    .err_sticky(es[0]), .stuck(st[0]));

  clk_div_monitor #(.CNT_W(8), .SYNC_STAGES(SYNC), .EXP_HIGH(4), .EXP_LOW(3), .TOL(1),
                    .TIMEOUT_CYC(TO_CYC)) u_tol (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .clk_in(clk_in), .meas_valid(mv[1]),
    .high_cnt(hc[1]), .low_cnt(lc[1]), .period_cnt(pc[1]), .err(er[1]),
    .err_sticky(es[1]), .stuck(st[1]));

  clk_div_monitor #(.CNT_W(8), .SYNC_STAGES(SYNC), .EXP_HIGH(2), .EXP_LOW(2), .TOL(1),
                    .TIMEOUT_CYC(TO_CYC)) u_half (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .clk_in(clk_in), .meas_valid(mv[2]),
    .high_cnt(hc[2]), .low_cnt(lc[2]), .period_cnt(pc[2]), .err(er[2]),
    .err_sticky(es[2]), .stuck(st[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic logic err_model(input int h, input int l, input int eh, input int el,
                                     input int tol);
    int dh, dl;
    dh = (h > eh) ? h - eh : eh - h;
    dl = (l > el) ? l - el : el - l;
    return (h >= 255) || (l >= 255) || (dh > tol) || (dl > tol);
  endfunction

  // Number of clk rising edges that sample a level driven over half-cycle slots [a,b].
  function automatic int count_even(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (i % 2 == 0) n++;
    return n;
  endfunction

  task automatic push_exp(input int h_raw, input int l_raw);
    exp_t x;
    x.h = sat(h_raw);
    x.l = sat(l_raw);
    x.p = x.h + x.l;
    x.e = err_model(x.h, x.l, 4, 3, 0); q0.push_back(x);
    x.e = err_model(x.h, x.l, 4, 3, 1); q1.push_back(x);
    x.e = err_model(x.h, x.l, 2, 2, 1); q2.push_back(x);
    last_h = x.h;
    last_l = x.l;
  endtask

  task automatic check_one(input int idx, input logic m, input logic e, input logic [7:0] h,
                           input logic [7:0] l, input logic [8:0] p);
    exp_t x;
    int   sz;
    if (m) begin
      sz = (idx == 0) ? q0.size() : (idx == 1) ? q1.size() : q2.size();
      if (sz == 0) begin
        chk($sformatf("u%0d_unexpected_meas_valid", idx), 32'd1, 32'd0);
      end else begin
        case (idx)
          0:       x = q0.pop_front();
          1:       x = q1.pop_front();
          default: x = q2.pop_front();
        endcase
        chk($sformatf("u%0d_high_cnt", idx), h, x.h);
        chk($sformatf("u%0d_low_cnt", idx), l, x.l);
        chk($sformatf("u%0d_period_cnt", idx), p, x.p);
        chk($sformatf("u%0d_err", idx), e, x.e);
      end
    end else if (e) begin
      chk($sformatf("u%0d_err_without_meas_valid", idx), e, 1'b0);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      check_one(0, mv[0], er[0], hc[0], lc[0], pc[0]);
      check_one(1, mv[1], er[1], hc[1], lc[1], pc[1]);
      check_one(2, mv[2], er[2], hc[2], lc[2], pc[2]);
      if (st[0]) stuck_seen++;
    end
  end

  task automatic set_for(input logic v, input int n);
    @(posedge clk); #1;
    clk_in = v;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic drive_period(input int h, input int l);
    push_exp(h, l);
    set_for(1'b1, h);
    set_for(1'b0, l);
  endtask

  // Period of 7 half-cycles: high for slots 0..3, low for slots 4..6, edges on both clk edges.
  task automatic half_section(input int n);
    for (int k = 0; k < n; k++)
      push_exp(count_even(7*k + 1, 7*k + 4), count_even(7*k + 5, 7*k + 7));
    for (int h = 0; h <= 7*n; h++) begin
      if (h % 2 == 0) @(posedge clk);
      else @(negedge clk);
      #1;
      clk_in = ((h % 7) < 4);
    end
  endtask

  // Closing rise for the last pending period, then park with en=0 and clk_in low.
  task automatic finish_section();
    set_for(1'b1, 6);
    @(posedge clk); #1;
    en = 1'b0;
    clk_in = 1'b0;
    repeat (6) @(posedge clk);
    for (int i = 0; i < 40 && (q0.size() + q1.size() + q2.size()) > 0; i++) @(posedge clk);
    chk("scoreboard_drained", q0.size() + q1.size() + q2.size(), 0);
    @(posedge clk); #1;
    en = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; en = 1'b0; clr = 1'b0; clk_in = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_meas_valid", mv[0], 0);
    chk("rst_high_cnt", hc[0], 0);
    chk("rst_low_cnt", lc[0], 0);
    chk("rst_period_cnt", pc[0], 0);
    chk("rst_err", er[0], 0);
    chk("rst_err_sticky", es[0], 0);
    chk("rst_stuck", st[0], 0);
    @(posedge clk); #1;
    rst = 1'b1; en = 1'b1;
    repeat (3) @(posedge clk);

    repeat (4) drive_period(4, 3);
    finish_section();
    chk("t1_def_sticky", es[0], 0);
    chk("t1_tol_sticky", es[1], 0);

    repeat (3) drive_period(5, 3);
    finish_section();
    chk("t2_def_sticky", es[0], 1);
    chk("t2_tol_sticky", es[1], 0);
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    chk("t2_def_sticky_clr", es[0], 0);
    chk("t2_half_sticky_clr", es[2], 0);

    half_section(4);
    finish_section();
    chk("t3_half_sticky", es[2], 0);
    chk("t3_def_sticky", es[0], 1);

`ifndef DIVMON_TIMEOUT_EN
    drive_period(300, 3);
    drive_period(4, 3);
    finish_section();
    chk("t4_tol_sticky", es[1], 1);
`endif

    set_for(1'b1, 3);
    @(posedge clk); #1 en = 1'b0;
    set_for(1'b0, 3);
    set_for(1'b1, 4);
    set_for(1'b0, 2);
    chk("t5_hold_high_cnt", hc[0], last_h);
    chk("t5_hold_low_cnt", lc[0], last_l);
    chk("t5_hold_period_cnt", pc[0], last_h + last_l);
    chk("t5_hold_err_sticky", es[0], 1);
    @(posedge clk); #1 en = 1'b1;
    repeat (2) drive_period(4, 3);
    finish_section();

    set_for(1'b1, 3);
    @(posedge clk); #1 rst = 1'b0;
    #1;
    chk("rst_mid_high_cnt", hc[0], 0);
    chk("rst_mid_period_cnt", pc[0], 0);
    chk("rst_mid_err_sticky", es[0], 0);
    @(posedge clk); #1 rst = 1'b1;
    last_h = 0; last_l = 0;
    finish_section();

`ifdef DIVMON_TIMEOUT_EN
    set_for(1'b1, 4);
    set_for(1'b0, 1);
    for (cnt = 1; cnt <= 200; cnt++) begin
      @(posedge clk); #1;
      if (st[0]) break;
    end
    chk("t6_stuck_latency", cnt, SYNC + 1 + TO_CYC);
    chk("t6_stuck_sticky", es[0], 1);
    @(posedge clk); #1 clr = 1'b1;
    chk("t6_stuck_one_cycle", st[0], 0);
    @(posedge clk); #1 clr = 1'b0;
    chk("t6_clr", es[0], 0);
    @(posedge clk); #1 clr = 1'b1;
    for (cnt = 1; cnt <= 200; cnt++) begin
      @(posedge clk); #1;
      if (st[0]) break;
    end
    chk("t6_stuck_repeat", cnt, TO_CYC - 3);
    chk("t6_set_beats_clr", es[0], 1);
    clr = 1'b0;
`else
    repeat (100) @(posedge clk);
    #1;
    chk("no_timeout_stuck_never", stuck_seen, 0);
    chk("no_timeout_sticky", es[0], 0);
`endif

    repeat (5) @(posedge clk);
    chk("final_drain", q0.size() + q1.size() + q2.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
